// File: rtl/spad_types_pkg.sv
// Shared scratchpad types: row geometry, requester ids, arbiter states and the
// request/response-tag payloads used by the scratchpad port arbiter.
package spad_types_pkg;

  localparam int unsigned SCPAD_ADDR_WIDTH = 16;
  localparam int unsigned SCPAD_ELEMS      = 8;
  localparam int unsigned SCPAD_ELEM_WIDTH = 8;
  localparam int unsigned SCPAD_DATA_WIDTH = SCPAD_ELEMS * SCPAD_ELEM_WIDTH;
  localparam int unsigned MAX_SRAM_DELAY   = 8;
  localparam int unsigned MAX_TILE_SIZE    = 32;

  typedef logic [SCPAD_DATA_WIDTH-1:0] scpad_data_t;
  typedef logic [SCPAD_ELEMS-1:0]      mask_t;

  typedef enum logic {
    SRC_FE = 1'b0,
    SRC_BE = 1'b1
  } src_t;

  // Arbiter states kept as plain constants so legacy code can compare raw codes
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ARB_IDLE    = 2'd0;
  localparam arb_state_t ARB_LOCK_FE = 2'd1;
  localparam arb_state_t ARB_LOCK_BE = 2'd2;

  typedef struct packed {
    logic                        write;
    logic                        lock;
    logic [SCPAD_ADDR_WIDTH-1:0] addr;
    scpad_data_t                 wdata;
    mask_t                       mask;
  } scpad_req_t;

  typedef struct packed {
    logic valid;
    src_t src;
  } rsp_tag_t;

endpackage

// File: rtl/scpad_rsp_tag_pipe.sv
// Fixed-depth shift register that tracks which requester owns each in-flight
// SRAM read, so read data can be steered back when it emerges.
module scpad_rsp_tag_pipe
  import spad_types_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  rsp_tag_t push_tag,
  output rsp_tag_t pop_tag
);

  rsp_tag_t stage [DEPTH];

  // Shifts every cycle regardless of SRAM backpressure; stalls insert bubbles
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= push_tag;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign pop_tag = stage[DEPTH-1];

endmodule

// File: rtl/scpad_port_arbiter.sv
// Round-robin arbiter sharing one scratchpad row port between FE and BE, with
// burst locking and latency-matched read-data return to the issuing side.
module scpad_port_arbiter
  import spad_types_pkg::*;
#(
  parameter int unsigned SRAM_LATENCY   = 2,
  parameter int unsigned MAX_LOCK_BEATS = MAX_TILE_SIZE
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        fe_req_valid,
  output logic                        fe_req_ready,
  input  logic                        fe_req_write,
  input  logic                        fe_req_lock,
  input  logic [SCPAD_ADDR_WIDTH-1:0] fe_req_addr,
  input  scpad_data_t                 fe_req_wdata,
  input  mask_t                       fe_req_mask,
  input  logic                        be_req_valid,
  output logic                        be_req_ready,
  input  logic                        be_req_write,
  input  logic                        be_req_lock,
  input  logic [SCPAD_ADDR_WIDTH-1:0] be_req_addr,
  input  scpad_data_t                 be_req_wdata,
  input  mask_t                       be_req_mask,
  output logic                        sram_req_valid,
  input  logic                        sram_req_ready,
  output logic                        sram_req_write,
  output logic [SCPAD_ADDR_WIDTH-1:0] sram_req_addr,
  output scpad_data_t                 sram_req_wdata,
  output mask_t                       sram_req_mask,
  input  scpad_data_t                 sram_rdata,
  output logic                        fe_rsp_valid,
  output scpad_data_t                 fe_rsp_data,
  output logic                        be_rsp_valid,
  output scpad_data_t                 be_rsp_data
);

  localparam int unsigned CNT_W = $clog2(MAX_LOCK_BEATS + 1);

  arb_state_t       state, state_n;
  src_t             last_src, last_src_n;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_n;

  logic       grant_fe_c, grant_be_c, accept_c;
  src_t       win_src_c;
  scpad_req_t fe_req_c, be_req_c, win_req_c;
  rsp_tag_t   push_tag_c, exit_tag;

  assign fe_req_c = '{write: fe_req_write, lock: fe_req_lock, addr: fe_req_addr,
                      wdata: fe_req_wdata, mask: fe_req_mask};
  assign be_req_c = '{write: be_req_write, lock: be_req_lock, addr: be_req_addr,
                      wdata: be_req_wdata, mask: be_req_mask};

  // Grant: lock owner only while locked, otherwise round-robin on ties
  always_comb begin
    grant_fe_c = 1'b0;
    grant_be_c = 1'b0;
    case (state)
      ARB_LOCK_FE: grant_fe_c = fe_req_valid;
      ARB_LOCK_BE: grant_be_c = be_req_valid;
      default: begin
        if (fe_req_valid && be_req_valid) begin
          grant_fe_c = (last_src == SRC_BE);
          grant_be_c = (last_src == SRC_FE);
        end else begin
          grant_fe_c = fe_req_valid;
          grant_be_c = be_req_valid;
        end
      end
    endcase
  end

  always_comb begin
    win_req_c = '0;
    if (grant_fe_c)      win_req_c = fe_req_c;
    else if (grant_be_c) win_req_c = be_req_c;
  end

  assign win_src_c      = grant_be_c ? SRC_BE : SRC_FE;
  assign sram_req_valid = grant_fe_c | grant_be_c;
  assign sram_req_write = win_req_c.write;
  assign sram_req_addr  = win_req_c.addr;
  assign sram_req_wdata = win_req_c.wdata;
  assign sram_req_mask  = win_req_c.mask;
  assign accept_c       = sram_req_valid & sram_req_ready;
  assign fe_req_ready   = grant_fe_c & sram_req_ready;
  assign be_req_ready   = grant_be_c & sram_req_ready;

  // Lock entry/exit; nothing advances without an accepted beat
  always_comb begin
    state_n    = state;
    last_src_n = last_src;
    beat_cnt_n = beat_cnt;
    if (accept_c) begin
      last_src_n = win_src_c;
      if (state == ARB_IDLE) begin
        if (win_req_c.lock && (MAX_LOCK_BEATS > 1)) begin
          state_n    = grant_fe_c ? ARB_LOCK_FE : ARB_LOCK_BE;
          beat_cnt_n = CNT_W'(1);
        end
      end else if (!win_req_c.lock || (beat_cnt == CNT_W'(MAX_LOCK_BEATS - 1))) begin
        state_n    = ARB_IDLE;
        beat_cnt_n = '0;
      end else begin
        beat_cnt_n = beat_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB_IDLE;
      last_src <= SRC_BE;
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      last_src <= last_src_n;
      beat_cnt <= beat_cnt_n;
    end
  end

  assign push_tag_c = '{valid: accept_c & ~win_req_c.write, src: win_src_c};

  scpad_rsp_tag_pipe #(
    .DEPTH (SRAM_LATENCY)
  ) u_tag_pipe (
    .clk      (clk),
    .rst      (rst),
    .push_tag (push_tag_c),
    .pop_tag  (exit_tag)
  );

  // Capture read data for whichever side owns the emerging tag
  always_ff @(posedge clk) begin
    if (rst) begin
      fe_rsp_valid <= 1'b0;
      be_rsp_valid <= 1'b0;
      fe_rsp_data  <= '0;
      be_rsp_data  <= '0;
    end else begin
      fe_rsp_valid <= exit_tag.valid && (exit_tag.src == SRC_FE);
      be_rsp_valid <= exit_tag.valid && (exit_tag.src == SRC_BE);
      if (exit_tag.valid && (exit_tag.src == SRC_FE)) fe_rsp_data <= sram_rdata;
      if (exit_tag.valid && (exit_tag.src == SRC_BE)) be_rsp_data <= sram_rdata;
    end
  end

endmodule

// File: tb/tb_scpad_port_arbiter.sv
// Randomized bench for scpad_port_arbiter against a cycle-level reference of
// the arbitration rules and a queue of expected read returns.
module tb_scpad_port_arbiter;
  import spad_types_pkg::*;

  localparam int unsigned LAT  = 2;
  localparam int unsigned MAXB = 32;
  localparam int unsigned HIST = 8192;

  logic                        clk, rst;
  logic                        fe_req_valid, fe_req_ready, fe_req_write, fe_req_lock;
  logic [SCPAD_ADDR_WIDTH-1:0] fe_req_addr;
  scpad_data_t                 fe_req_wdata;
  mask_t                       fe_req_mask;
  logic                        be_req_valid, be_req_ready, be_req_write, be_req_lock;
  logic [SCPAD_ADDR_WIDTH-1:0] be_req_addr;
  scpad_data_t                 be_req_wdata;
  mask_t                       be_req_mask;
  logic                        sram_req_valid, sram_req_ready, sram_req_write;
  logic [SCPAD_ADDR_WIDTH-1:0] sram_req_addr;
  scpad_data_t                 sram_req_wdata, sram_rdata;
  mask_t                       sram_req_mask;
  logic                        fe_rsp_valid, be_rsp_valid;
  scpad_data_t                 fe_rsp_data, be_rsp_data;

  scpad_port_arbiter #(
    .SRAM_LATENCY   (LAT),
    .MAX_LOCK_BEATS (MAXB)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fe_req_valid   (fe_req_valid),
    .fe_req_ready   (fe_req_ready),
    .fe_req_write   (fe_req_write),
    .fe_req_lock    (fe_req_lock),
    .fe_req_addr    (fe_req_addr),
    .fe_req_wdata   (fe_req_wdata),
    .fe_req_mask    (fe_req_mask),
    .be_req_valid   (be_req_valid),
    .be_req_ready   (be_req_ready),
    .be_req_write   (be_req_write),
    .be_req_lock    (be_req_lock),
    .be_req_addr    (be_req_addr),
    .be_req_wdata   (be_req_wdata),
    .be_req_mask    (be_req_mask),
    .sram_req_valid (sram_req_valid),
    .sram_req_ready (sram_req_ready),
    .sram_req_write (sram_req_write),
    .sram_req_addr  (sram_req_addr),
    .sram_req_wdata (sram_req_wdata),
    .sram_req_mask  (sram_req_mask),
    .sram_rdata     (sram_rdata),
    .fe_rsp_valid   (fe_rsp_valid),
    .fe_rsp_data    (fe_rsp_data),
    .be_rsp_valid   (be_rsp_valid),
    .be_rsp_data    (be_rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int due;
    int src;
  } pend_t;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          owner;   // -1 = no lock, 0 = FE, 1 = BE
  int          last;    // side that won the most recent accept
  int          beats;
  pend_t       pend[$];
  scpad_data_t fe_last, be_last;
  scpad_data_t rdata_hist [HIST];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic void model_reset();
    owner   = -1;
    last    = 1;
    beats   = 0;
    fe_last = '0;
    be_last = '0;
    pend.delete();
  endfunction

  // One clock: random drive, compare against the reference, advance reference
  task automatic step(input int pfe, input int pbe, input int plock, input int pwr,
                      input int prdy, input int prst);
    int          win;
    bit          acc, do_rst, ef, eb;
    logic        e_wr;
    logic [SCPAD_ADDR_WIDTH-1:0] e_addr;
    scpad_data_t e_wd;
    mask_t       e_mk;
    @(posedge clk);
    #1;
    fe_req_valid   = ($urandom_range(99) < pfe);
    fe_req_write   = ($urandom_range(99) < pwr);
    fe_req_lock    = ($urandom_range(99) < plock);
    fe_req_addr    = SCPAD_ADDR_WIDTH'($urandom);
    fe_req_wdata   = {$urandom, $urandom};
    fe_req_mask    = mask_t'($urandom);
    be_req_valid   = ($urandom_range(99) < pbe);
    be_req_write   = ($urandom_range(99) < pwr);
    be_req_lock    = ($urandom_range(99) < plock);
    be_req_addr    = SCPAD_ADDR_WIDTH'($urandom);
    be_req_wdata   = {$urandom, $urandom};
    be_req_mask    = mask_t'($urandom);
    sram_req_ready = ($urandom_range(99) < prdy);
    sram_rdata     = {$urandom, $urandom};
    do_rst         = ($urandom_range(99) < prst);
    rst            = do_rst;
    rdata_hist[cyc] = sram_rdata;
    @(negedge clk);

    if (owner == 0)                        win = fe_req_valid ? 0 : -1;
    else if (owner == 1)                   win = be_req_valid ? 1 : -1;
    else if (fe_req_valid && be_req_valid) win = (last == 0) ? 1 : 0;
    else if (fe_req_valid)                 win = 0;
    else if (be_req_valid)                 win = 1;
    else                                   win = -1;
    acc = (win >= 0) && sram_req_ready;

    e_wr = 1'b0; e_addr = '0; e_wd = '0; e_mk = '0;
    if (win == 0) begin
      e_wr = fe_req_write; e_addr = fe_req_addr; e_wd = fe_req_wdata; e_mk = fe_req_mask;
    end else if (win == 1) begin
      e_wr = be_req_write; e_addr = be_req_addr; e_wd = be_req_wdata; e_mk = be_req_mask;
    end
    chk("fe_ready", 64'(fe_req_ready), 64'(win == 0 && sram_req_ready));
    chk("be_ready", 64'(be_req_ready), 64'(win == 1 && sram_req_ready));
    chk("sram_valid", 64'(sram_req_valid), 64'(win >= 0));
    chk("sram_write", 64'(sram_req_write), 64'(e_wr));
    chk("sram_addr", 64'(sram_req_addr), 64'(e_addr));
    chk("sram_wdata", sram_req_wdata, e_wd);
    chk("sram_mask", 64'(sram_req_mask), 64'(e_mk));

    ef = 1'b0; eb = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      if (pend[0].src == 0) begin ef = 1'b1; fe_last = rdata_hist[cyc-1]; end
      else                  begin eb = 1'b1; be_last = rdata_hist[cyc-1]; end
      void'(pend.pop_front());
    end
    chk("fe_rsp_valid", 64'(fe_rsp_valid), 64'(ef));
    chk("be_rsp_valid", 64'(be_rsp_valid), 64'(eb));
    chk("fe_rsp_data", fe_rsp_data, fe_last);
    chk("be_rsp_data", be_rsp_data, be_last);

    if (do_rst) begin
      model_reset();
    end else if (acc) begin
      if (!e_wr) pend.push_back('{due: cyc + int'(LAT) + 1, src: win});
      last = win;
      if (owner < 0) begin
        if ((win == 0) ? fe_req_lock : be_req_lock) begin
          owner = win;
          beats = 1;
        end
      end else begin
        beats++;
        if (!((win == 0) ? fe_req_lock : be_req_lock) || beats == int'(MAXB)) begin
          owner = -1;
          beats = 0;
        end
      end
    end
    cyc++;
  endtask

  initial begin
    rst = 1'b1;
    fe_req_valid = 1'b0; fe_req_write = 1'b0; fe_req_lock = 1'b0;
    fe_req_addr = '0; fe_req_wdata = '0; fe_req_mask = '0;
    be_req_valid = 1'b0; be_req_write = 1'b0; be_req_lock = 1'b0;
    be_req_addr = '0; be_req_wdata = '0; be_req_mask = '0;
    sram_req_ready = 1'b0; sram_rdata = '0;
    repeat (3) @(posedge clk);
    model_reset();

    repeat (4)   step(0,   0,   0,   0,   100, 0);  // idle after reset
    repeat (40)  step(100, 100, 0,   20,  100, 0);  // plain round-robin
    repeat (100) step(100, 100, 100, 30,  100, 0);  // held locks, forced release
    repeat (300) step(60,  60,  30,  40,  80,  0);  // mixed traffic with stalls
    repeat (20)  step(100, 100, 100, 0,   100, 0);  // reads in flight under lock
    step(100, 100, 100, 0, 100, 100);               // reset mid-burst
    repeat (10)  step(100, 100, 0,   0,   100, 0);
    repeat (300) step(50,  50,  25,  30,  70,  2);  // sporadic resets
    repeat (LAT + 2) step(0, 0, 0, 0, 100, 0);      // drain

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scpad_port_arbiter.md
Name: scpad_port_arbiter

Overview:
- Shares one scratchpad row port between the frontend (SRC_FE) and backend (SRC_BE) requesters.
- Each request is one full row: read or masked write.
- Arbitration is round-robin. A requester may lock the port for a multi-row burst, e.g. a tile transfer.
- Returns read data to the issuing requester after the fixed SRAM latency. Sits between the FE/BE request logic and the scratchpad bank array.

Parameters:
- SRAM_LATENCY, 2, cycles from accepted read to sram_rdata valid; legal range 1..MAX_SRAM_DELAY.
- MAX_LOCK_BEATS, MAX_TILE_SIZE (32), maximum accepted beats in one locked burst.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous, active-high reset
- fe_req_valid  in  1  FE request valid
- fe_req_ready  out  1  FE request accepted this cycle
- fe_req_write  in  1  1 = write, 0 = read
- fe_req_lock  in  1  hold the port after this beat
- fe_req_addr  in  SCPAD_ADDR_WIDTH  row byte address
- fe_req_wdata  in  scpad_data_t  write data
- fe_req_mask  in  mask_t  per-element write enable
- be_req_valid/ready/write/lock/addr/wdata/mask  same widths and meanings, BE side
- sram_req_valid  out  1  request to scratchpad
- sram_req_ready  in  1  scratchpad accepts
- sram_req_write  out  1  muxed write flag
- sram_req_addr  out  SCPAD_ADDR_WIDTH  muxed address
- sram_req_wdata  out  scpad_data_t  muxed write data
- sram_req_mask  out  mask_t  muxed mask
- sram_rdata  in  scpad_data_t  read data, valid SRAM_LATENCY cycles after read accept
- fe_rsp_valid  out  1  FE read data valid
- fe_rsp_data  out  scpad_data_t  FE read data
- be_rsp_valid  out  1  BE read data valid
- be_rsp_data  out  scpad_data_t  BE read data

Behaviour:
- Accept condition: sram_req_valid && sram_req_ready. x_req_ready = grant_x && sram_req_ready (combinational). At most one grant per cycle.
- Request path is combinational: the winner's fields drive sram_req_* in the same cycle. With no valid requester, sram_req_valid=0 and the other sram_req_* fields are 0.
- Arbiter state: IDLE, LOCK_FE, LOCK_BE. Registers: last_src (src_t), beat_cnt ($clog2(MAX_LOCK_BEATS+1) bits).
- IDLE arbitration:
  - One requester valid: it wins.
  - Both valid: the source != last_src wins.
  - last_src updates on every accept.
- IDLE transitions: an accepted beat with lock=1 moves to LOCK_src, with beat_cnt=1.
- LOCK_x:
  - Only x may be granted. The other requester is held off (ready=0) even if x is idle.
  - Each accepted x beat increments beat_cnt.
  - Exit to IDLE on an accepted beat with lock=0, or on the accept that brings beat_cnt to MAX_LOCK_BEATS (forced release).
  - After release, last_src=x, so a waiting other requester wins the next cycle.
  - x dropping valid does not release the lock.
- Response path:
  - A tag shift register of depth SRAM_LATENCY carries {valid, src} for each accepted read. Writes push valid=0.
  - When a tag exits, sram_rdata is registered into the matching rsp_data and rsp_valid pulses for 1 cycle.
  - Total read latency is SRAM_LATENCY+1 cycles from the accept edge to rsp_valid.
  - No response backpressure; requesters must always sink responses.
  - Back-to-back reads are fully pipelined, one per cycle.
- Unselected rsp_data holds its previous value.
- Reset (RST=1 at a clock edge):
  - state=IDLE, last_src=SRC_BE (FE wins the first tie), beat_cnt=0.
  - Tag pipeline cleared.
  - fe/be_rsp_valid=0, fe/be_rsp_data=0.
  - Reset mid-burst or with reads in flight drops them; no response is issued.
- sram_req_ready=0 stalls the grant. Arbitration state, last_src and beat_cnt do not advance, and the tag pipeline still shifts (a bubble enters).
- A request and an unrelated response in the same cycle are independent.

Decomposition:
- Add to spad_types_pkg:
  - typedef arb_state_t {ARB_IDLE, ARB_LOCK_FE, ARB_LOCK_BE}.
  - struct scpad_req_t {write, lock, addr, wdata, mask}.
  - struct rsp_tag_t {valid, src_t src}.
- One sub-module: scpad_rsp_tag_pipe (parameterised depth, carries rsp_tag_t) for the response-routing shift register.

Test Plan:
- FE read of addr 0x40 alone, SRAM_LATENCY=2, sram_rdata=0xA5A5 pattern at accept+2 -> fe_rsp_valid at accept+3 with that data; be_rsp_valid stays 0.
- FE and BE both valid continuously after reset, no lock -> grants alternate FE, BE, FE, BE; each ready pulses every other cycle.
- BE writes 4 beats with lock=1,1,1,0 while FE is valid -> FE ready=0 for those 4 accepts; FE granted the cycle after the lock=0 beat.
- FE locks with lock held at 1 and MAX_LOCK_BEATS=32, BE waiting -> forced release after the 32nd accept; BE granted next; beat_cnt returns to 0.
- Interleaved FE read, BE read, FE write back-to-back, then sram_req_ready=0 for 2 cycles -> rsp_valid pulses FE then BE in consecutive cycles with correct data; no grant during the stall; the write produces no response.
- RST asserted with 2 reads in flight and LOCK_BE active -> no rsp_valid after reset; state IDLE; FE wins the first simultaneous request.
